// File: rtl/nibble_pkg.sv
// Shared types and sizing helpers for the nibble collector.
package nibble_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Index counter width; at least one bit so NIBBLES=2 still has a real register.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_idx_ctr.sv
// Slot index counter: wraps from NIBBLES-1 back to 0, clear has priority.
module nibble_idx_ctr
  import nibble_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            inc,
  input  logic                            clr,
  output logic [idx_width(NIBBLES)-1:0]   idx,
  output logic                            last
);

  localparam int unsigned IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NIBBLES - 1);

  assign last = (idx == IDX_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + IDX_W'(1);
    end
  end

  a_idx_in_range: assert property (@(posedge clk) disable iff (rst) idx <= IDX_MAX);

endmodule

// File: rtl/nibble_collector.sv
// Assembles NIBBLES masked 4-bit words LSB-first into one word with an AND-reduction,
// presented on a registered valid/ready port with no bubble between words.
module nibble_collector
  import nibble_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W-1:0]          in_data,
  input  logic [NIBBLE_W-1:0]          in_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLES*NIBBLE_W-1:0]  out_word,
  output logic [NIBBLE_W-1:0]          out_and,
  output logic                         out_partial
);

  localparam int unsigned WORD_W = NIBBLES * NIBBLE_W;
  localparam int unsigned IDX_W  = idx_width(NIBBLES);

  if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_nibbles
    $error("nibble_collector: NIBBLES must be in 2..8");
  end

  state_t                state;
  state_t                state_next;
  logic [IDX_W-1:0]      idx;
  logic                  last;
  logic                  accept;
  logic                  complete;
  logic                  flush_partial;
  logic [NIBBLE_W-1:0]   nibble;
  logic [WORD_W-1:0]     part_word;
  logic [WORD_W-1:0]     word_next;
  logic [NIBBLE_W-1:0]   red;
  logic [NIBBLE_W-1:0]   red_next;
  logic                  pending;

  nibble_idx_ctr #(
    .NIBBLES (NIBBLES)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .clr  (flush_partial),
    .idx  (idx),
    .last (last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; idx is 0 in HOLD so an accept there can never complete a word
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (complete)  state_next = HOLD;
      HOLD:    if (out_ready) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Output logic: handshake signals decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: in_ready = !flush;
      HOLD: begin
        in_ready  = !flush && out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath decode for the current nibble
  always_comb begin
    nibble        = in_data & in_mask;
    accept        = in_valid && in_ready;
    complete      = accept && last;
    flush_partial = flush && (state == COLLECT) && (idx != '0);
    red_next      = red & nibble;
    word_next     = part_word;
    word_next[int'(idx)*NIBBLE_W +: NIBBLE_W] = nibble;
  end

  // Slot, reduction and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_word   <= '0;
      red         <= '1;
      pending     <= 1'b0;
      out_word    <= '0;
      out_and     <= '1;
      out_partial <= 1'b0;
    end else if (complete) begin
      out_word    <= word_next;
      out_and     <= red_next;
      out_partial <= pending;
      pending     <= 1'b0;
      part_word   <= '0;
      red         <= '1;
    end else if (accept) begin
      part_word <= word_next;
      red       <= red_next;
    end else if (flush_partial) begin
      part_word <= '0;
      red       <= '1;
      pending   <= 1'b1;
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (state == HOLD && !out_ready) |=> ($stable(out_word) && $stable(out_and)));

endmodule

// File: tb/tb_nibble_collector.sv
// Directed bench for nibble_collector with NIBBLES=4 and NIBBLES=2 instances.
module tb_nibble_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready, out_partial;
  logic [3:0]  in_data, in_mask, out_and;
  logic [15:0] out_word;

  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2, out_partial2;
  logic [3:0]  in_data2, in_mask2, out_and2;
  logic [7:0]  out_word2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_collector #(.NIBBLES(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_and(out_and), .out_partial(out_partial)
  );

  nibble_collector #(.NIBBLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_mask(in_mask2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_word(out_word2), .out_and(out_and2), .out_partial(out_partial2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic [3:0] m);
    in_valid = 1'b1; in_data = d; in_mask = m;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [3:0] d, input logic [3:0] m);
    in_valid2 = 1'b1; in_data2 = d; in_mask2 = m;
    step();
    in_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 0; in_valid = 0; in_data = 0; in_mask = 0; out_ready = 0;
    flush2 = 0; in_valid2 = 0; in_data2 = 0; in_mask2 = 0; out_ready2 = 0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_word !== 16'h0) begin errors++; $display("FAIL reset_word: got %h expected 0000", out_word); end
    checks++; if (out_and !== 4'hF) begin errors++; $display("FAIL reset_and: got %h expected f", out_and); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL reset_partial: got %b expected 0", out_partial); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(4'h1, 4'hF); send(4'h2, 4'hF); send(4'h3, 4'hF); send(4'h4, 4'hF);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    checks++; if (out_word !== 16'h4321) begin errors++; $display("FAIL basic_word: got %h expected 4321", out_word); end
    checks++; if (out_and !== 4'h0) begin errors++; $display("FAIL basic_and: got %h expected 0", out_and); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL basic_partial: got %b expected 0", out_partial); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_mask();
    out_ready = 1'b1;
    send(4'hF, 4'hE); send(4'h7, 4'hF); send(4'hF, 4'hF); send(4'h6, 4'hF);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mask_valid: got %b expected 1", out_valid); end
    checks++; if (out_word !== 16'h6F7E) begin errors++; $display("FAIL mask_word: got %h expected 6f7e", out_word); end
    checks++; if (out_and !== 4'h6) begin errors++; $display("FAIL mask_and: got %h expected 6", out_and); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(4'h1, 4'hF); send(4'h2, 4'hF); send(4'h3, 4'hF); send(4'h4, 4'hF);
    in_valid = 1'b1; in_data = 4'hA; in_mask = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready); end
      checks++; if (out_word !== 16'h4321) begin errors++; $display("FAIL bp_word cycle %0d: got %h expected 4321", c, out_word); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    send(4'hB, 4'hF); send(4'hC, 4'hF); send(4'hD, 4'hF);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
    checks++; if (out_word !== 16'hDCBA) begin errors++; $display("FAIL b2b_word: got %h expected dcba", out_word); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(4'h1, 4'hF); send(4'h2, 4'hF);
    flush = 1'b1; in_valid = 1'b1; in_data = 4'h9; in_mask = 4'hF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    send(4'h5, 4'hF); send(4'h6, 4'hF); send(4'h7, 4'hF); send(4'h8, 4'hF);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b expected 1", out_valid); end
    checks++; if (out_word !== 16'h8765) begin errors++; $display("FAIL flush_word: got %h expected 8765", out_word); end
    checks++; if (out_partial !== 1'b1) begin errors++; $display("FAIL flush_partial: got %b expected 1", out_partial); end
    step();
    send(4'h1, 4'hF); send(4'h1, 4'hF); send(4'h1, 4'hF); send(4'h1, 4'hF);
    checks++; if (out_word !== 16'h1111) begin errors++; $display("FAIL clean_word: got %h expected 1111", out_word); end
    checks++; if (out_and !== 4'h1) begin errors++; $display("FAIL clean_and: got %h expected 1", out_and); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL clean_partial: got %b expected 0", out_partial); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    send(4'h1, 4'hF); send(4'h2, 4'hF); send(4'h3, 4'hF);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    checks++; if (out_word !== 16'h0) begin errors++; $display("FAIL arst_word: got %h expected 0000", out_word); end
    checks++; if (out_and !== 4'hF) begin errors++; $display("FAIL arst_and: got %h expected f", out_and); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL arst_partial: got %b expected 0", out_partial); end
    checks++; if (u_dut.u_ctr.idx !== 2'd0) begin errors++; $display("FAIL arst_idx: got %0d expected 0", u_dut.u_ctr.idx); end
    #2 rst = 1'b0;
    step();
    send(4'hB, 4'hF); send(4'hC, 4'hF); send(4'hD, 4'hF); send(4'hE, 4'hF);
    checks++; if (out_word !== 16'hEDCB) begin errors++; $display("FAIL arst_next_word: got %h expected edcb", out_word); end
    checks++; if (out_and !== 4'h8) begin errors++; $display("FAIL arst_next_and: got %h expected 8", out_and); end
    step();
  endtask

  task automatic test_two_nibbles();
    out_ready2 = 1'b1;
    send2(4'h5, 4'hF); send2(4'hA, 4'hF);
    checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL n2_valid: got %b expected 1", out_valid2); end
    checks++; if (out_word2 !== 8'hA5) begin errors++; $display("FAIL n2_word: got %h expected a5", out_word2); end
    checks++; if (out_and2 !== 4'h0) begin errors++; $display("FAIL n2_and: got %h expected 0", out_and2); end
    checks++; if (u_dut2.u_ctr.idx !== 1'b0) begin errors++; $display("FAIL n2_idx_wrap: got %0d expected 0", u_dut2.u_ctr.idx); end
    step();
    send2(4'h3, 4'hF); send2(4'h7, 4'hF);
    checks++; if (out_word2 !== 8'h73) begin errors++; $display("FAIL n2_word2: got %h expected 73", out_word2); end
    checks++; if (out_and2 !== 4'h3) begin errors++; $display("FAIL n2_and2: got %h expected 3", out_and2); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_two_nibbles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_collector.md
# nibble_collector

Receive-side counterpart to the 4-bit output-register producers in the hardware regression set. The block accepts a stream of 4-bit output words (data plus a per-bit enable mask) over a valid/ready handshake. It assembles NIBBLES of them LSB-first into one wide word and presents the word on a registered valid/ready output port. It also registers the bitwise AND-reduction across the collected nibbles, which makes it the consumer that closes the loop on producer/consumer port-passing tests.

## Interface
- NIBBLES, 4, nibbles per output word; legal range 2..8
- NIBBLE_W, 4, width of one input word; fixed, lives in the package
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- flush  input  1  synchronous abort of a partial word
- in_valid  input  1  upstream nibble present
- in_ready  output  1  block accepts the nibble this cycle
- in_data  input  4  nibble value
- in_mask  input  4  enable bits; the stored nibble is in_data & in_mask
- out_valid  output  1  a completed word is held
- out_ready  input  1  downstream takes the word
- out_word  output  4*NIBBLES  assembled word; nibble k at bits [4k+3:4k]
- out_and  output  4  AND of all stored nibbles of out_word
- out_partial  output  1  sticky flag: the last word was preceded by a flushed partial word

## Operation
- States:
  - COLLECT: gathering nibbles.
  - HOLD: completed word waiting for downstream.
- Reset (async, active-high) forces all of the following:
  - state = COLLECT, idx = 0, partial word = 0
  - out_valid = 0, out_word = 0, out_and = 4'hF, out_partial = 0
  - No transfer occurs while rst is high.
- Accept condition: in_valid && in_ready.
- in_ready = !flush && (state==COLLECT || (state==HOLD && out_ready)).
- COLLECT, on accept:
  - Store in_data & in_mask into slot idx and AND it into the running reduction.
  - If idx == NIBBLES-1: latch the full word into out_word and the reduction into out_and; go to HOLD; clear idx and the partial registers.
  - Otherwise increment idx.
- HOLD:
  - out_valid = 1; out_word and out_and are stable until the output handshake.
  - On out_ready, go to COLLECT.
  - If a nibble is accepted in the same cycle as out_ready, it is stored in slot 0 of the next word. This gives back-to-back streaming with no bubble.
- flush:
  - In COLLECT with idx != 0: clear idx and the partial word; set the pending-partial bit. The nibble offered that cycle is dropped, since in_ready is low.
  - In COLLECT with idx == 0: no effect.
  - In HOLD: the held word is never discarded. The output handshake still completes if out_ready is high, but no new nibble is accepted that cycle.
- out_partial: loaded from the pending-partial bit when a word enters HOLD; the pending-partial bit then clears.
- Width rules:
  - idx is clog2(NIBBLES) bits and never exceeds NIBBLES-1.
  - out_and over an all-zero mask word is 4'h0.

## Timing
- Latency: the last nibble is accepted on edge n; out_valid = 1 from edge n until the edge after out_ready.
- in_ready is combinational from state, flush and out_ready. All other outputs are registers.
- Throughput: one nibble per cycle sustained; a word completes every NIBBLES cycles while out_ready is held high.
- Asserting reset mid-word or mid-HOLD discards everything immediately; the first nibble accepted after reset goes to slot 0.

## Structure
- Package nibble_pkg:
  - NIBBLE_W = 4
  - state enum {COLLECT, HOLD}
  - function giving idx width from NIBBLES
- Sub-module nibble_idx_ctr: the index counter. Inputs are inc, clr and rst; outputs are idx and last (idx == NIBBLES-1). It is instantiated once.
- The top level holds the state register, slot registers, reduction register and output registers.

## Test plan
- Basic word: NIBBLES=4, mask F; send 1,2,3,4 with out_ready high.
  - One cycle after the 4th accept: out_valid = 1, out_word = 16'h4321, out_and = 4'h0, out_partial = 0.
- Mask and reduction: send F/mask E, 7/mask F, F/mask F, 6/mask F.
  - out_word = 16'h6F7E, out_and = 4'h6.
- Backpressure and streaming:
  - Complete a word with out_ready = 0: in_ready stays 0 and out_word stays stable for 5 cycles.
  - Then raise out_ready while offering A: the word drains and A lands in slot 0. Three more nibbles later the next word is valid with low nibble A.
- Flush: send 1,2; assert flush while offering 9; then send 5,6,7,8.
  - 9 is not accepted. out_word = 16'h8765, out_partial = 1.
  - The next clean word has out_partial = 0.
- Async reset mid-word: send 3 nibbles, pulse rst between clock edges.
  - out_valid, out_word, idx and out_partial return to 0 at once, out_and returns to F.
  - Next 4 nibbles B,C,D,E give 16'hEDCB.
- NIBBLES=2: send 5,A.
  - out_word = 8'hA5, out_and = 4'h0.
  - idx wraps 1→0 with no out-of-range write.
